// File: rtl/me_pkg.sv
// Shared motion-estimation definitions: datapath widths, the SAD search FSM
// states, the pipeline tag, the best-result record and an abs-diff helper.
package me_pkg;

  localparam int PIX_W        = 8;
  localparam int PIX_PER_ROW  = 8;
  localparam int ROW_W        = PIX_W * PIX_PER_ROW;
  localparam int ROWS_PER_BLK = 8;
  localparam int ROW_IDX_W    = 3;
  localparam int NUM_CAND     = 64;
  localparam int IDX_W        = 6;
  localparam int SAD_W        = 14;
  localparam int ROWSUM_W     = PIX_W + 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [SAD_W-1:0] sad;
    logic [IDX_W-1:0] idx;
  } best_t;

  typedef struct packed {
    logic [IDX_W-1:0]     idx;
    logic [ROW_IDX_W-1:0] row;
    logic                 last;
  } tag_t;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    if (a >= b) begin
      return a - b;
    end else begin
      return b - a;
    end
  endfunction

endpackage

// File: rtl/sad_row8.sv
// Row SAD stage: registered per-pixel |cur-ref|, then a registered 8->4->2->1
// adder tree. Two-cycle latency; an opaque tag rides along with the valid bit.
module sad_row8
  import me_pkg::*;
#(
  parameter int TAG_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [ROW_W-1:0]    cur_row_i,
  input  logic [ROW_W-1:0]    ref_row_i,
  input  logic [TAG_W-1:0]    tag_i,
  output logic                valid_o,
  output logic [ROWSUM_W-1:0] rowsum_o,
  output logic [TAG_W-1:0]    tag_o
);

  logic [PIX_W-1:0]    diff_d [PIX_PER_ROW];
  logic [PIX_W-1:0]    diff_q [PIX_PER_ROW];
  logic                v1_q;
  logic [TAG_W-1:0]    tag1_q;
  logic [PIX_W:0]      sum4_s [4];
  logic [PIX_W+1:0]    sum2_s [2];
  logic [ROWSUM_W-1:0] sum1_s;
  logic [ROWSUM_W-1:0] rowsum_q;
  logic                v2_q;
  logic [TAG_W-1:0]    tag2_q;

  // Per-pixel absolute differences.
  always_comb begin
    for (int k = 0; k < PIX_PER_ROW; k++) begin
      diff_d[k] = abs_diff(cur_row_i[k*PIX_W +: PIX_W], ref_row_i[k*PIX_W +: PIX_W]);
    end
  end

  // Stage 1 register: differences, valid and tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      tag1_q <= '0;
      for (int k = 0; k < PIX_PER_ROW; k++) begin
        diff_q[k] <= '0;
      end
    end else begin
      v1_q <= valid_i;
      if (valid_i) begin
        tag1_q <= tag_i;
        for (int k = 0; k < PIX_PER_ROW; k++) begin
          diff_q[k] <= diff_d[k];
        end
      end
    end
  end

  // Adder tree, each level one bit wider so no carry is lost.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sum4_s[k] = {1'b0, diff_q[2*k]} + {1'b0, diff_q[2*k+1]};
    end
    for (int k = 0; k < 2; k++) begin
      sum2_s[k] = {1'b0, sum4_s[2*k]} + {1'b0, sum4_s[2*k+1]};
    end
    sum1_s = {1'b0, sum2_s[0]} + {1'b0, sum2_s[1]};
  end

  // Stage 2 register: row sum, valid and tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q     <= 1'b0;
      tag2_q   <= '0;
      rowsum_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        tag2_q   <= tag1_q;
        rowsum_q <= sum1_s;
      end
    end
  end

  assign valid_o  = v2_q;
  assign rowsum_o = rowsum_q;
  assign tag_o    = tag2_q;

endmodule

// File: rtl/sad8x8_best.sv
// 8x8 SAD best-candidate search: FSM, row/candidate counters, accumulator and
// minimum tracking. Optional early rejection with macro SAD_EARLY_TERM_EN.
module sad8x8_best
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             row_valid,
  input  logic [ROW_W-1:0] cur_row,
  input  logic [ROW_W-1:0] ref_row,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
  output logic             skip_req
);

  localparam best_t BEST_INIT = '{sad: {SAD_W{1'b1}}, idx: {IDX_W{1'b0}}};

  state_e               state_q, state_d;
  logic                 busy_q;
  logic                 done_q;
  best_t                best_q;
  logic [ROW_IDX_W-1:0] row_cnt_q;
  logic [IDX_W-1:0]     cand_cnt_q;
  logic                 accept_s;
  logic                 start_acc_s;
  logic                 last_row_s;
  logic                 final_s;
  tag_t                 tag_in_s;
  logic                 s2_valid_s;
  tag_t                 s2_tag_s;
  logic [ROWSUM_W-1:0]  rowsum_s;
  logic                 s3_valid_q;
  tag_t                 s3_tag_q;
  logic [SAD_W-1:0]     acc_q;
  logic                 rej_block_s;
  logic                 upd_s;

  assign last_row_s = (cand_cnt_q == IDX_W'(NUM_CAND - 1)) && (row_cnt_q == 3'd7);
  assign final_s    = s3_valid_q && s3_tag_q.last;

  // Next-state logic; rows are only accepted in RUN.
  always_comb begin
    state_d     = state_q;
    accept_s    = 1'b0;
    start_acc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          start_acc_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        accept_s = row_valid;
        if (row_valid && last_row_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (final_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and busy flag (busy falls together with the done pulse).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Row and candidate counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt_q  <= '0;
      cand_cnt_q <= '0;
    end else if (start_acc_s) begin
      row_cnt_q  <= '0;
      cand_cnt_q <= '0;
    end else if (accept_s) begin
      row_cnt_q <= row_cnt_q + 3'd1;
      if (row_cnt_q == 3'd7) begin
        cand_cnt_q <= cand_cnt_q + IDX_W'(1);
      end
    end
  end

  assign tag_in_s = '{idx: cand_cnt_q, row: row_cnt_q, last: last_row_s};

  sad_row8 #(
    .TAG_W ($bits(tag_t))
  ) u_sad_row8 (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (accept_s),
    .cur_row_i (cur_row),
    .ref_row_i (ref_row),
    .tag_i     (tag_in_s),
    .valid_o   (s2_valid_s),
    .rowsum_o  (rowsum_s),
    .tag_o     (s2_tag_s)
  );

  // Stage 3: per-candidate accumulator, restarted on row 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
      s3_tag_q   <= '0;
      acc_q      <= '0;
    end else begin
      s3_valid_q <= s2_valid_s;
      if (s2_valid_s) begin
        s3_tag_q <= s2_tag_s;
        if (s2_tag_s.row == 3'd0) begin
          acc_q <= SAD_W'(rowsum_s);
        end else begin
          acc_q <= acc_q + SAD_W'(rowsum_s);
        end
      end
    end
  end

  // Strict less-than keeps the lower index on ties since candidates arrive in order.
  assign upd_s = s3_valid_q && (s3_tag_q.row == 3'd7) && (acc_q < best_q.sad) && !rej_block_s;

  // Stage 4: best tracking and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= BEST_INIT;
      done_q <= 1'b0;
    end else begin
      done_q <= final_s;
      if (start_acc_s) begin
        best_q <= BEST_INIT;
      end else if (upd_s) begin
        best_q <= '{sad: acc_q, idx: s3_tag_q.idx};
      end
    end
  end

`ifdef SAD_EARLY_TERM_EN
  logic skip_q;
  logic s3_rej_q;
  logic rej_now_s;

  // Partial sums only grow, so reaching best_sad early already rules the candidate out.
  assign rej_now_s = s3_valid_q && (acc_q >= best_q.sad);

  // Rejection bookkeeping for the pipeline and the upstream skip hint.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_rej_q <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      if (s3_valid_q) begin
        s3_rej_q <= (s3_tag_q.row == 3'd7) ? 1'b0 : (s3_rej_q | rej_now_s);
      end
      if (start_acc_s) begin
        skip_q <= 1'b0;
      end else if (accept_s && (row_cnt_q == 3'd7)) begin
        skip_q <= 1'b0;
      end else if (rej_now_s && (state_q == ST_RUN) && (s3_tag_q.idx == cand_cnt_q)) begin
        skip_q <= 1'b1;
      end
    end
  end

  assign rej_block_s = s3_rej_q;
  assign skip_req    = skip_q;
`else
  assign rej_block_s = 1'b0;
  assign skip_req    = 1'b0;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign best_sad = best_q.sad;
  assign best_idx = best_q.idx;

endmodule

// File: tb/tb_sad8x8_best.sv
// Directed self-checking bench for sad8x8_best: tie rule, latency, max SAD,
// random gapped searches against a small model, abort, back-to-back, skip_req.
module tb_sad8x8_best;

  logic        clk = 1'b0;
  logic        rst, start, row_valid;
  logic [63:0] cur_row, ref_row;
  logic        busy, done, skip_req;
  logic [13:0] best_sad;
  logic [5:0]  best_idx;

  int errors = 0;
  int checks = 0;

  logic [63:0] cur_mem [512];
  logic [63:0] ref_mem [512];
  logic        skip_log [512];

  always #5 clk = ~clk;

  sad8x8_best dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .row_valid (row_valid),
    .cur_row   (cur_row),
    .ref_row   (ref_row),
    .busy      (busy),
    .done      (done),
    .best_sad  (best_sad),
    .best_idx  (best_idx),
    .skip_req  (skip_req)
  );

  task automatic fill(input int mode);
    int c, r;
    logic [7:0] cp, rp;
    for (int n = 0; n < 512; n++) begin
      c = n / 8;
      r = n % 8;
      for (int k = 0; k < 8; k++) begin
        case (mode)
          1: begin cp = 8'(c + 3*r + k); rp = (c == 5) ? cp + 8'd1 : cp; end
          2: begin cp = 8'd0; rp = 8'(63 - c); end
          3: begin cp = 8'hFF; rp = 8'h00; end
          4: begin cp = 8'($urandom); rp = 8'($urandom); end
          5: begin cp = 8'($urandom_range(3, 0)); rp = 8'($urandom_range(3, 0)); end
          default: begin
            cp = 8'd0;
            rp = 8'd0;
            if (r == 0) begin
              if (c == 1) rp = 8'd25;
              else if (k == 0) rp = (c == 0) ? 8'd10 : 8'd20;
            end
          end
        endcase
        cur_mem[n][8*k +: 8] = cp;
        ref_mem[n][8*k +: 8] = rp;
      end
    end
  endtask

  task automatic model(output int exp_sad, output int exp_idx);
    int s, a, b;
    exp_sad = 1 << 30;
    exp_idx = 0;
    for (int c = 0; c < 64; c++) begin
      s = 0;
      for (int r = 0; r < 8; r++) begin
        for (int k = 0; k < 8; k++) begin
          a = int'(cur_mem[c*8+r][8*k +: 8]);
          b = int'(ref_mem[c*8+r][8*k +: 8]);
          s += (a > b) ? a - b : b - a;
        end
      end
      if (s < exp_sad) begin
        exp_sad = s;
        exp_idx = c;
      end
    end
  endtask

  // Drives one search from cur_mem/ref_mem; returns done latency (-1 on timeout),
  // count of cycles with busy low while it should be high, and busy in the done cycle.
  task automatic run_search(input bit b2b, input bit gaps, input int abort_n,
                            input bit drain_rows, output int lat_o,
                            output int busy_bad_o, output logic busy_done_o);
    int n;
    lat_o       = -1;
    busy_bad_o  = 0;
    busy_done_o = 1'bx;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n < 512) begin
      if (busy !== 1'b1) busy_bad_o++;
      if (abort_n == n) begin
        rst       = 1'b1;
        row_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (gaps && ($urandom_range(1, 0) == 0)) begin
        row_valid = 1'b0;
        start     = 1'b0;
        cur_row   = 64'hFFFF_FFFF_FFFF_FFFF;
        ref_row   = 64'h0;
      end else begin
        row_valid   = 1'b1;
        cur_row     = cur_mem[n];
        ref_row     = ref_mem[n];
        skip_log[n] = skip_req;
        start       = (n == 100);
        n++;
      end
      @(posedge clk); #1;
    end
    start     = 1'b0;
    row_valid = drain_rows;
    cur_row   = 64'hFFFF_FFFF_FFFF_FFFF;
    ref_row   = 64'h0;
    for (int i = 1; i <= 12 && lat_o < 0; i++) begin
      if (done === 1'b1) begin
        lat_o       = i;
        busy_done_o = busy;
      end else begin
        if (busy !== 1'b1) busy_bad_o++;
        @(posedge clk); #1;
      end
    end
    row_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; row_valid = 1'b0; cur_row = '0; ref_row = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (best_sad !== 14'h3FFF) begin errors++; $display("FAIL reset_sad: got %0d want 16383", best_sad); end
    checks++; if (best_idx !== 6'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", best_idx); end
    checks++; if (skip_req !== 1'b0) begin errors++; $display("FAIL reset_skip: got %b want 0", skip_req); end
    row_valid = 1'b1; cur_row = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) @(posedge clk);
    #1 row_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_rows_busy: got %b want 0", busy); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL idle_rows_done: got %b want 0", done); end
  endtask

  task automatic test_tie();
    int lat, bb; logic bd;
    fill(1);
    run_search(1'b0, 1'b0, -1, 1'b0, lat, bb, bd);
    checks++; if (lat != 4) begin errors++; $display("FAIL tie_latency: got %0d want 4", lat); end
    checks++; if (best_sad !== 14'd0) begin errors++; $display("FAIL tie_sad: got %0d want 0", best_sad); end
    checks++; if (best_idx !== 6'd0) begin errors++; $display("FAIL tie_idx: got %0d want 0", best_idx); end
    checks++; if (bb != 0) begin errors++; $display("FAIL tie_busy: got %0d low cycles want 0", bb); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL tie_busy_at_done: got %b want 0", bd); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || best_sad !== 14'd0) begin
      errors++; $display("FAIL tie_hold: got done=%b sad=%0d want done=0 sad=0", done, best_sad);
    end
  endtask

  task automatic test_latency();
    int lat, bb; logic bd;
    fill(2);
    run_search(1'b0, 1'b0, -1, 1'b1, lat, bb, bd);
    checks++; if (lat != 4) begin errors++; $display("FAIL lat_latency: got %0d want 4", lat); end
    checks++; if (best_sad !== 14'd0) begin errors++; $display("FAIL lat_sad: got %0d want 0", best_sad); end
    checks++; if (best_idx !== 6'd63) begin errors++; $display("FAIL lat_idx: got %0d want 63", best_idx); end
    checks++; if (bb != 0) begin errors++; $display("FAIL lat_busy: got %0d low cycles want 0", bb); end
  endtask

  task automatic test_max_sad();
    int lat, bb; logic bd;
    fill(3);
    run_search(1'b0, 1'b0, -1, 1'b0, lat, bb, bd);
    checks++; if (lat != 4) begin errors++; $display("FAIL max_latency: got %0d want 4", lat); end
    checks++; if (best_sad !== 14'd16320) begin errors++; $display("FAIL max_sad: got %0d want 16320", best_sad); end
    checks++; if (best_idx !== 6'd0) begin errors++; $display("FAIL max_idx: got %0d want 0", best_idx); end
  endtask

  task automatic test_random();
    int lat, bb, es, ei; logic bd;
    for (int t = 0; t < 3; t++) begin
      fill((t == 1) ? 5 : 4);
      model(es, ei);
      run_search(1'b0, (t != 2), -1, 1'b0, lat, bb, bd);
      checks++; if (lat != 4) begin errors++; $display("FAIL rnd%0d_latency: got %0d want 4", t, lat); end
      checks++; if (bb != 0) begin errors++; $display("FAIL rnd%0d_busy: got %0d low cycles want 0", t, bb); end
      checks++; if (int'(best_sad) != es) begin errors++; $display("FAIL rnd%0d_sad: got %0d want %0d", t, best_sad, es); end
      checks++; if (int'(best_idx) != ei) begin errors++; $display("FAIL rnd%0d_idx: got %0d want %0d", t, best_idx, ei); end
    end
  endtask

  task automatic test_abort();
    int lat, bb, ndone; logic bd;
    fill(2);
    run_search(1'b0, 1'b0, 20*8 + 3, 1'b0, lat, bb, bd);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (best_sad !== 14'h3FFF) begin errors++; $display("FAIL abort_sad: got %0d want 16383", best_sad); end
    checks++; if (best_idx !== 6'd0) begin errors++; $display("FAIL abort_idx: got %0d want 0", best_idx); end
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done !== 1'b0) ndone++;
      @(posedge clk); #1;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL abort_no_done: got %0d done cycles want 0", ndone); end
  endtask

  task automatic test_back_to_back();
    int lat, bb; logic bd;
    fill(2);
    run_search(1'b0, 1'b0, -1, 1'b0, lat, bb, bd);
    checks++; if (best_sad !== 14'd0 || best_idx !== 6'd63) begin
      errors++; $display("FAIL b2b_first: got sad=%0d idx=%0d want sad=0 idx=63", best_sad, best_idx);
    end
    fill(3);
    run_search(1'b1, 1'b0, -1, 1'b0, lat, bb, bd);
    checks++; if (lat != 4) begin errors++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    checks++; if (bb != 0) begin errors++; $display("FAIL b2b_busy: got %0d low cycles want 0", bb); end
    checks++; if (best_sad !== 14'd16320) begin errors++; $display("FAIL b2b_sad: got %0d want 16320", best_sad); end
    checks++; if (best_idx !== 6'd0) begin errors++; $display("FAIL b2b_idx: got %0d want 0", best_idx); end
  endtask

  task automatic test_early_term();
    int lat, bb, nbad, first_bad; logic bd;
    logic exp_skip [512];
    for (int n = 0; n < 512; n++) begin
`ifdef SAD_EARLY_TERM_EN
      exp_skip[n] = (n >= 8) && ((n % 8) >= 4);
`else
      exp_skip[n] = 1'b0;
`endif
    end
    fill(6);
    run_search(1'b0, 1'b0, -1, 1'b0, lat, bb, bd);
    checks++; if (best_sad !== 14'd10) begin errors++; $display("FAIL et_sad: got %0d want 10", best_sad); end
    checks++; if (best_idx !== 6'd0) begin errors++; $display("FAIL et_idx: got %0d want 0", best_idx); end
    nbad = 0;
    first_bad = -1;
    for (int n = 0; n < 512; n++) begin
      if (skip_log[n] !== exp_skip[n]) begin
        nbad++;
        if (first_bad < 0) first_bad = n;
      end
    end
    checks++; if (nbad != 0) begin
      errors++; $display("FAIL et_skip: got %0d wrong rows (first row %0d) want 0", nbad, first_bad);
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_latency();
    test_max_sad();
    test_random();
    test_abort();
    test_back_to_back();
    test_early_term();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
